// File: rtl/coef_poly_eval.sv
// coef_poly_eval: pipelined piecewise-quadratic evaluator driving a combinational coefficient ROM.
//   y = ((C2*x >>> XW) + C1) * x >>> XW + C0, one sample per cycle, latency 4 edges.
//   clk, reset            clock and synchronous active-high reset
//   in_valid/in_ready     input handshake for in_addr (segment) and in_x (Q0.XW offset)
//   address, read_en      ROM address (registered) and read strobe
//   Coef2/Coef1/Coef0     signed ROM return for the current address
//   out_valid/out_ready   output handshake for signed result y
module coef_poly_eval #(
    parameter int XW     = 16,
    parameter int ADDR_W = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [XW-1:0]            in_x,
    output logic [ADDR_W-1:0]        address,
    output logic                     read_en,
    input  logic signed [17:0]       Coef2,
    input  logic signed [17:0]       Coef1,
    input  logic signed [20:0]       Coef0,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [21:0]       y
);
    localparam int PW1 = 19 + XW;
    localparam int PW2 = 20 + XW;
    logic              stall;
    logic [3:0]        v_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XW-1:0]     x0_q, x1_q, x2_q;
    logic signed [17:0] t1_q, c1_1_q;
    logic signed [20:0] c0_1_q, c0_2_q, c0_3_q;
    logic signed [18:0] s2_q, u3_q;
    logic signed [21:0] y_q;
    logic              out_valid_q;
    logic signed [17:0] t_d;
    logic signed [18:0] s_d, u_d;
    logic signed [21:0] y_d;
    // Operands are widened before multiplying so the full product exists before
    // the arithmetic shift; x gets a zero sign bit so it stays non-negative.
    assign t_d = 18'((PW1'(Coef2) * PW1'($signed({1'b0, x0_q}))) >>> XW);
    assign s_d = 19'(t1_q) + 19'(c1_1_q);
    assign u_d = 19'((PW2'(s2_q) * PW2'($signed({1'b0, x2_q}))) >>> XW);
    assign y_d = 22'(u3_q) + 22'(c0_3_q);
    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign address   = addr_q;
    assign read_en   = v_q[0] & ~stall;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q         <= '0;
            addr_q      <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            t1_q        <= '0;
            c1_1_q      <= '0;
            c0_1_q      <= '0;
            c0_2_q      <= '0;
            c0_3_q      <= '0;
            s2_q        <= '0;
            u3_q        <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else if (!stall) begin
            v_q         <= {v_q[2:0], in_valid};
            addr_q      <= in_addr;
            x0_q        <= in_x;
            t1_q        <= t_d;
            c1_1_q      <= Coef1;
            c0_1_q      <= Coef0;
            x1_q        <= x0_q;
            s2_q        <= s_d;
            c0_2_q      <= c0_1_q;
            x2_q        <= x1_q;
            u3_q        <= u_d;
            c0_3_q      <= c0_2_q;
            // y only changes when a real sample arrives so bubbles leave it untouched.
            y_q         <= v_q[3] ? y_d : y_q;
            out_valid_q <= v_q[3];
        end
    end
endmodule

// File: tb/tb_coef_poly_eval.sv
// tb_coef_poly_eval: directed and scoreboard checks of coef_poly_eval against a behavioural ROM stub.
module tb_coef_poly_eval;
    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [6:0]         in_addr;
    logic [15:0]        in_x;
    logic [6:0]         address;
    logic               read_en;
    logic signed [17:0] Coef2, Coef1;
    logic signed [20:0] Coef0;
    logic               out_valid;
    logic               out_ready;
    logic signed [21:0] y;
    int c2_rom [128];
    int c1_rom [128];
    int c0_rom [128];
    longint exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    coef_poly_eval dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_x(in_x), .address(address), .read_en(read_en),
        .Coef2(Coef2), .Coef1(Coef1), .Coef0(Coef0),
        .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    always #5 clk = ~clk;

    assign Coef2 = 18'(c2_rom[address]);
    assign Coef1 = 18'(c1_rom[address]);
    assign Coef0 = 21'(c0_rom[address]);

    function automatic longint model(longint c2, longint c1, longint c0, longint x);
        longint t, s, u;
        t = (c2 * x) >>> 16;
        s = t + c1;
        u = (s * x) >>> 16;
        return u + c0;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int x);
        bit ok;
        int tries;
        in_valid = 1'b1;
        in_addr  = 7'(a);
        in_x     = 16'(x);
        tries    = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!ok && tries < 64);
        if (!ok) chk("send_timeout", longint'(ok), 1);
    endtask

    task automatic run_one(input string tag, input int a, input int x, input longint expv);
        send(a, x);
        in_valid = 1'b0;
        repeat (3) tick();
        chk({tag, "_early"}, longint'(out_valid), 0);
        tick();
        chk({tag, "_valid"}, longint'(out_valid), 1);
        chk({tag, "_y"}, longint'(y), expv);
        tick();
    endtask

    // Scoreboard: predict at input transfer, compare at output transfer.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                n_tests++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_output: observed y=%0d expected no output", y);
                end
                if (exp_q.size() != 0) begin
                    longint e;
                    e = exp_q.pop_front();
                    n_tests++;
                    assert (longint'(y) === e) else begin
                        n_fail++;
                        $error("FAIL scoreboard: observed %0d expected %0d", y, e);
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(c2_rom[in_addr], c1_rom[in_addr], c0_rom[in_addr], longint'(in_x)));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic signed [21:0] yh;
        reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_x = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_y", longint'(y), 0);
        chk("rst_read_en", longint'(read_en), 0);
        chk("rst_address", longint'(address), 0);
        chk("rst_in_ready", longint'(in_ready), 1);

        c2_rom[3] = 0;      c1_rom[3] = 0;  c0_rom[3] = 100;
        c2_rom[1] = 65536;  c1_rom[1] = 0;  c0_rom[1] = 0;
        c2_rom[2] = 0;      c1_rom[2] = -4; c0_rom[2] = 10;
        c2_rom[4] = 0;      c1_rom[4] = -1; c0_rom[4] = 5;
        c2_rom[5] = -65536; c1_rom[5] = 100; c0_rom[5] = -7;

        send(3, 16'h1234);
        in_valid = 1'b0;
        chk("t1_read_en_on", longint'(read_en), 1);
        chk("t1_address", longint'(address), 3);
        chk("t1_out_early", longint'(out_valid), 0);
        tick();
        chk("t1_read_en_off", longint'(read_en), 0);
        tick(); tick();
        chk("t1_out_k3", longint'(out_valid), 0);
        tick();
        chk("t1_out_k4", longint'(out_valid), 1);
        chk("t1_y", longint'(y), 100);
        tick();

        run_one("t2", 1, 16'h8000, 16384);
        run_one("t3a", 2, 16'h8000, 8);
        run_one("t3b", 4, 1, 4);

        for (int i = 0; i < 128; i++) begin
            c2_rom[i] = int'($urandom_range(0, 262143)) - 131072;
            c1_rom[i] = int'($urandom_range(0, 262143)) - 131072;
            c0_rom[i] = int'($urandom_range(0, 2097151)) - 1048576;
        end
        base = n_out;
        for (int i = 0; i < 128; i++) send(i, int'($urandom_range(0, 65535)));
        in_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        #1;
        chk("t4_count", longint'(n_out - base), 128);
        chk("t4_drained", longint'(exp_q.size()), 0);

        tick();
        base = n_out;
        for (int i = 0; i < 5; i++) send(i + 10, int'($urandom_range(0, 65535)));
        in_valid = 1'b1; in_addr = 7'd15; in_x = 16'h7777;
        out_ready = 1'b0;
        #1;
        chk("t5_stall_valid", longint'(out_valid), 1);
        chk("t5_stall_in_ready", longint'(in_ready), 0);
        yh = y;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t5_hold_valid", longint'(out_valid), 1);
            chk("t5_hold_y", longint'(y), longint'(yh));
            chk("t5_hold_in_ready", longint'(in_ready), 0);
            chk("t5_hold_read_en", longint'(read_en), 0);
        end
        out_ready = 1'b1;
        for (int i = 5; i < 20; i++) send(i + 10, (i == 5) ? 16'h7777 : int'($urandom_range(0, 65535)));
        in_valid = 1'b0;
        repeat (8) tick();
        chk("t5_count", longint'(n_out - base), 20);
        chk("t5_drained", longint'(exp_q.size()), 0);

        c2_rom[5] = -65536; c1_rom[5] = 100; c0_rom[5] = -7;
        for (int i = 0; i < 3; i++) send(i + 40, int'($urandom_range(0, 65535)));
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_out_valid", longint'(out_valid), 0);
        chk("t6_y", longint'(y), 0);
        chk("t6_read_en", longint'(read_en), 0);
        chk("t6_in_ready", longint'(in_ready), 1);
        base = n_out;
        repeat (8) tick();
        chk("t6_no_ghosts", longint'(n_out - base), 0);
        run_one("t6_new", 5, 16'h4000, -4078);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
